// File: rtl/p_column_reader.sv
// Serial P byte transposition: registers a 512-bit block and streams its eight
// 64-bit transposed column words with a valid/ready handshake.
module p_column_reader #(
    parameter int WORD_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [511:0]      block_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic [2:0]        idx_o,
    output logic              last_o,
    output logic              valid_o,
    input  logic              ready_i
);

    // state | meaning
    // IDLE  | no block held, ready for a new one, valid_o low
    // SEND  | streaming words idx_o = 0..7 of the held block

    if (WORD_W != 64) begin : g_width_check
        $error("p_column_reader: WORD_W must be 64");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state;
    logic [511:0] blk_q;
    logic         accept;
    logic         fire;

    // Word k, byte j = block byte 8j+k.
    function automatic logic [WORD_W-1:0] column(input logic [511:0] blk, input logic [2:0] k);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            w[8*j +: 8] = blk[64*j + 8*int'(k) +: 8];
        end
        return w;
    endfunction

    // A new block may land on the same edge the last word leaves.
    assign ready_o = !rst_i && ((state == IDLE) || (idx_o == 3'd7 && ready_i));
    assign accept  = valid_i && ready_o;
    assign fire    = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            idx_o   <= 3'd0;
            last_o  <= 1'b0;
            word_o  <= '0;
        end else if (accept) begin
            blk_q   <= block_i;
            state   <= SEND;
            valid_o <= 1'b1;
            idx_o   <= 3'd0;
            last_o  <= 1'b0;
            word_o  <= column(block_i, 3'd0);
        end else if (state == SEND && fire) begin
            if (idx_o == 3'd7) begin
                state   <= IDLE;
                valid_o <= 1'b0;
                idx_o   <= 3'd0;
                last_o  <= 1'b0;
            end else begin
                idx_o   <= idx_o + 3'd1;
                last_o  <= (idx_o == 3'd6);
                word_o  <= column(blk_q, idx_o + 3'd1);
            end
        end
    end

endmodule
